// File: rtl/led_sequencer.sv
// Programmable LED pattern sequencer driving the mask/brightness inputs of the 8-LED PWM driver.
// Optional `LED_SEQ_FADE_EN: out_level ramps 1 LSB per tick toward each step target.
module led_sequencer #(
    parameter int unsigned CLK_FREQ = 25_000_000,
    parameter int unsigned TICK_HZ  = 1000,
    parameter int unsigned STEPS    = 8,
    localparam int unsigned AW      = $clog2(STEPS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [AW-1:0] cfg_addr,
    input  logic [7:0]    cfg_mask,
    input  logic [7:0]    cfg_level,
    input  logic [15:0]   cfg_dur,
    input  logic          cfg_last,
    input  logic          start,
    input  logic          stop,
    input  logic          loop_en,
    output logic          busy,
    output logic [AW-1:0] step_idx,
    output logic [7:0]    out_mask,
    output logic [7:0]    out_level,
    output logic          out_update
);

    localparam int unsigned TICK_DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2
    } state_e;

    // Program RAM, flop-based so it can be cleared by reset.
    logic [7:0]  mem_mask  [STEPS];
    logic [7:0]  mem_level [STEPS];
    logic [15:0] mem_dur   [STEPS];
    logic        mem_last  [STEPS];

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW-1:0] step_idx_q, step_idx_d;
    logic [7:0]    mask_q, mask_d;
    logic [7:0]    level_q, level_d;
    logic          update_q, update_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   dur_cnt_q, dur_cnt_d;
    logic          last_q, last_d;
`ifdef LED_SEQ_FADE_EN
    logic [7:0]    target_q, target_d;
`endif

    logic wr_en;
    logic tick;
    logic final_step;

    assign cfg_ready  = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign wr_en      = cfg_valid && cfg_ready;
    assign tick       = (presc_q == PW'(TICK_DIV - 1));
    assign final_step = last_q || (idx_q == AW'(STEPS - 1));

    assign step_idx   = step_idx_q;
    assign out_mask   = mask_q;
    assign out_level  = level_q;
    assign out_update = update_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                mem_mask[i]  <= '0;
                mem_level[i] <= '0;
                mem_dur[i]   <= '0;
                mem_last[i]  <= 1'b0;
            end
        end else if (wr_en) begin
            mem_mask[cfg_addr]  <= cfg_mask;
            mem_level[cfg_addr] <= cfg_level;
            mem_dur[cfg_addr]   <= cfg_dur;
            mem_last[cfg_addr]  <= cfg_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            step_idx_q <= '0;
            mask_q     <= '0;
            level_q    <= '0;
            update_q   <= 1'b0;
            presc_q    <= '0;
            dur_cnt_q  <= '0;
            last_q     <= 1'b0;
`ifdef LED_SEQ_FADE_EN
            target_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            step_idx_q <= step_idx_d;
            mask_q     <= mask_d;
            level_q    <= level_d;
            update_q   <= update_d;
            presc_q    <= presc_d;
            dur_cnt_q  <= dur_cnt_d;
            last_q     <= last_d;
`ifdef LED_SEQ_FADE_EN
            target_q   <= target_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        step_idx_d = step_idx_q;
        mask_d     = mask_q;
        level_d    = level_q;
        update_d   = 1'b0;
        presc_d    = presc_q;
        dur_cnt_d  = dur_cnt_q;
        last_d     = last_q;
`ifdef LED_SEQ_FADE_EN
        target_d   = target_q;
`endif

        if (stop) begin
            // Abort beats start and a coincident step end.
            state_d    = StIdle;
            idx_d      = '0;
            step_idx_d = '0;
            mask_d     = '0;
            level_d    = '0;
            presc_d    = '0;
            dur_cnt_d  = '0;
            last_d     = 1'b0;
`ifdef LED_SEQ_FADE_EN
            target_d   = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StLoad;
                        idx_d   = '0;
                    end
                end
                StLoad: begin
                    mask_d     = mem_mask[idx_q];
                    step_idx_d = idx_q;
                    dur_cnt_d  = (mem_dur[idx_q] == 16'd0) ? 16'd1 : mem_dur[idx_q];
                    last_d     = mem_last[idx_q];
                    presc_d    = '0;
                    update_d   = 1'b1;
                    state_d    = StRun;
`ifdef LED_SEQ_FADE_EN
                    target_d   = mem_level[idx_q];
`else
                    level_d    = mem_level[idx_q];
`endif
                end
                StRun: begin
                    if (tick) begin
                        presc_d   = '0;
                        dur_cnt_d = dur_cnt_q - 16'd1;
`ifdef LED_SEQ_FADE_EN
                        if (level_q < target_q) begin
                            level_d = level_q + 8'd1;
                        end else if (level_q > target_q) begin
                            level_d = level_q - 8'd1;
                        end
`endif
                        if (dur_cnt_q <= 16'd1) begin
                            if (!final_step) begin
                                idx_d   = idx_q + AW'(1);
                                state_d = StLoad;
                            end else if (loop_en) begin
                                idx_d   = '0;
                                state_d = StLoad;
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer: stimulus queues expected out_update events, a monitor
// pops and checks them; level/busy/reset checks are made inline by the stimulus.
module tb_led_sequencer;

    localparam int STEPS = 4;
    localparam int AW    = 2;
`ifdef LED_SEQ_FADE_EN
    localparam bit FADE = 1'b1;
`else
    localparam bit FADE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [AW-1:0] cfg_addr;
    logic [7:0]    cfg_mask;
    logic [7:0]    cfg_level;
    logic [15:0]   cfg_dur;
    logic          cfg_last;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic          busy;
    logic [AW-1:0] step_idx;
    logic [7:0]    out_mask;
    logic [7:0]    out_level;
    logic          out_update;

    led_sequencer #(
        .CLK_FREQ(1000),
        .TICK_HZ (100),
        .STEPS   (STEPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_addr  (cfg_addr),
        .cfg_mask  (cfg_mask),
        .cfg_level (cfg_level),
        .cfg_dur   (cfg_dur),
        .cfg_last  (cfg_last),
        .start     (start),
        .stop      (stop),
        .loop_en   (loop_en),
        .busy      (busy),
        .step_idx  (step_idx),
        .out_mask  (out_mask),
        .out_level (out_level),
        .out_update(out_update)
    );

    always #5 clk = ~clk;

    // cyc == number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        int       idx;
        int       mask;
        int       level;
    } upd_t;

    upd_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, req);
        end
    endtask

    task automatic push(input int c, input int idx, input int mask, input int level);
        upd_t e;
        e.cyc   = c;
        e.idx   = idx;
        e.mask  = mask;
        e.level = level;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && out_update === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_update @cyc %0d: idx=%0d mask=0x%0h level=%0d",
                         cyc, step_idx, out_mask, out_level);
            end else begin
                upd_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.idx != int'(step_idx) || e.mask != int'(out_mask) ||
                    e.level != int'(out_level)) begin
                    miscompares++;
                    $display("FAIL update: got cyc=%0d idx=%0d mask=0x%0h level=%0d, want cyc=%0d idx=%0d mask=0x%0h level=%0d",
                             cyc, step_idx, out_mask, out_level, e.cyc, e.idx, e.mask, e.level);
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic write_step(input int addr, input int mask, input int level, input int dur,
                              input int last);
        cfg_addr  = AW'(addr);
        cfg_mask  = 8'(mask);
        cfg_level = 8'(level);
        cfg_dur   = 16'(dur);
        cfg_last  = 1'(last);
        cfg_valid = 1'b1;
        check("cfg_ready_idle", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    // Issues start at a negedge; returns N, the edge that samples it.
    task automatic start_pulse(output int n);
        start = 1'b1;
        n     = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_cfg_ready"}, int'(cfg_ready), 1);
        check({tag, "_step_idx"}, int'(step_idx), 0);
        check({tag, "_mask"}, int'(out_mask), 0);
        check({tag, "_level"}, int'(out_level), 0);
        check({tag, "_update"}, int'(out_update), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int ks[8] = '{0, 1, 5, 9, 10, 11, 15, 19};

        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_mask = '0; cfg_level = '0;
        cfg_dur = '0; cfg_last = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two-step one-shot program, with a stray start mid-RUN.
        write_step(0, 'h55, 255, 3, 0);
        write_step(1, 'hAA, 0, 2, 1);
        push(cyc + 2, 0, 'h55, FADE ? 0 : 255);
        push(cyc + 33, 1, 'hAA, FADE ? 3 : 0);
        start_pulse(n);
        check("busy_after_start", int'(busy), 1);
        wait_cyc(n + 15);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(n + 51);
        check("busy_before_end", int'(busy), 1);
        @(negedge clk);
        check("busy_after_end", int'(busy), 0);
        check("hold_mask", int'(out_mask), 'hAA);
        check("hold_level", int'(out_level), FADE ? 1 : 0);
        check("hold_idx", int'(step_idx), 1);
        do_stop();
        check("stop_idle_mask", int'(out_mask), 0);
        check("stop_idle_level", int'(out_level), 0);
        check("stop_idle_idx", int'(step_idx), 0);

        // start and stop together in IDLE: no LOAD.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy0", int'(busy), 0);
        @(negedge clk);
        check("start_stop_busy1", int'(busy), 0);

        // Four-step loop; dur=0 acts as 1; write while busy is dropped; stop at a step end.
        write_step(0, 'h01, 10, 1, 0);
        write_step(1, 'h02, 20, 0, 0);
        write_step(2, 'h04, 30, 2, 0);
        write_step(3, 'h08, 40, 1, 0);
        loop_en = 1'b1;
        push(cyc + 2, 0, 'h01, FADE ? 0 : 10);
        push(cyc + 13, 1, 'h02, FADE ? 1 : 20);
        push(cyc + 24, 2, 'h04, FADE ? 2 : 30);
        push(cyc + 45, 3, 'h08, FADE ? 4 : 40);
        push(cyc + 56, 0, 'h01, FADE ? 5 : 10);
        push(cyc + 67, 1, 'h02, FADE ? 6 : 20);
        start_pulse(n);
        wait_cyc(n + 5);
        cfg_addr  = '0;
        cfg_mask  = 8'hFF;
        cfg_level = 8'd99;
        cfg_dur   = 16'd9;
        cfg_last  = 1'b1;
        cfg_valid = 1'b1;
        check("cfg_ready_busy", int'(cfg_ready), 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_cyc(n + 76);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_end_busy", int'(busy), 0);
        check("stop_end_mask", int'(out_mask), 0);
        check("stop_end_level", int'(out_level), 0);
        check("stop_end_idx", int'(step_idx), 0);
        @(negedge clk);
        check("stop_end_no_update", int'(out_update), 0);
        loop_en = 1'b0;

        // Long step then short step: fade ramps, or plain step levels.
        write_step(0, 'h0F, 10, 20, 0);
        write_step(1, 'hF0, 0, 4, 1);
        push(cyc + 2, 0, 'h0F, FADE ? 0 : 10);
        push(cyc + 203, 1, 'hF0, FADE ? 10 : 0);
        start_pulse(n);
        foreach (ks[i]) begin
            wait_cyc(n + 1 + 10 * ks[i] + 3);
            check("ramp_level", int'(out_level), FADE ? ((ks[i] > 10) ? 10 : ks[i]) : 10);
        end
        wait_cyc(n + 241);
        check("ramp_busy_before_end", int'(busy), 1);
        @(negedge clk);
        check("ramp_busy_after_end", int'(busy), 0);
        check("ramp_final_level", int'(out_level), FADE ? 6 : 0);
        do_stop();

        // Asynchronous reset mid-RUN, then replay the cleared RAM.
        push(cyc + 2, 0, 'h0F, FADE ? 0 : 10);
        start_pulse(n);
        wait_cyc(n + 5);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push(cyc + 2, 0, 0, 0);
        push(cyc + 13, 1, 0, 0);
        push(cyc + 24, 2, 0, 0);
        push(cyc + 35, 3, 0, 0);
        start_pulse(n);
        wait_cyc(n + 43);
        check("clr_busy_before_end", int'(busy), 1);
        @(negedge clk);
        check("clr_busy_after_end", int'(busy), 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
